// File: rtl/within_frame_gen.sv
// Generator for the b/c/a "window within frame" pattern: b for N cycles, a one-cycle
// c terminator, and an a window placed at a programmed offset inside that span.
module within_frame_gen #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [LEN_W-1:0] win_off,
  input  logic [LEN_W-1:0] win_len,
  output logic             b,
  output logic             c,
  output logic             a,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, BODY, TAIL} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] frameLen_q;
  logic [LEN_W-1:0] winOff_q;
  logic [LEN_W:0]   winEnd_q;
  logic [LEN_W:0]   pos_q;

  logic [LEN_W:0]   reqEnd_d;
  logic             reqLegal_d;
  logic [LEN_W:0]   pos_d;
  logic [LEN_W:0]   lastPos;

  // The window end is one bit wider so offset + length cannot wrap.
  always_comb begin
    reqEnd_d   = {1'b0, win_off} + {1'b0, win_len};
    reqLegal_d = (frame_len != '0) && (win_len != '0) &&
                 (reqEnd_d <= ({1'b0, frame_len} + (LEN_W+1)'(1)));
    pos_d      = pos_q + (LEN_W+1)'(1);
    lastPos    = {1'b0, frameLen_q} - (LEN_W+1)'(1);
  end

  function automatic logic inWindow(input logic [LEN_W:0] p,
                                    input logic [LEN_W-1:0] off,
                                    input logic [LEN_W:0] winEnd);
    return (p >= {1'b0, off}) && (p < winEnd);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frameLen_q <= '0;
      winOff_q   <= '0;
      winEnd_q   <= '0;
      pos_q      <= '0;
      b          <= 1'b0;
      c          <= 1'b0;
      a          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            frameLen_q <= frame_len;
            winOff_q   <= win_off;
            winEnd_q   <= reqEnd_d;
            if (reqLegal_d) begin
              state_q <= BODY;
              pos_q   <= '0;
              b       <= 1'b1;
              busy    <= 1'b1;
              // Position 0 is inside the window only for a zero offset (length is nonzero).
              a       <= (win_off == '0);
            end else begin
              err <= 1'b1;
            end
          end
        end
        BODY: begin
          pos_q <= pos_d;
          a     <= inWindow(pos_d, winOff_q, winEnd_q);
          if (pos_q == lastPos) begin
            state_q <= TAIL;
            b       <= 1'b0;
            c       <= 1'b1;
          end
        end
        TAIL: begin
          state_q <= IDLE;
          c       <= 1'b0;
          a       <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          b       <= 1'b0;
          c       <= 1'b0;
          a       <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_within_frame_gen.sv
// Scoreboard bench for within_frame_gen: expected {b,c,a,busy,done,err} vectors are
// derived from the frame timing formulas, queued at stimulus time, popped each cycle.
module tb_within_frame_gen;

  localparam int LEN_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic [LEN_W-1:0] win_off;
  logic [LEN_W-1:0] win_len;
  logic             b, c, a, busy, done, err;

  int checks   = 0;
  int failures = 0;
  logic [5:0] expQ[$];
  string curTag;

  within_frame_gen #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frame_len(frame_len), .win_off(win_off), .win_len(win_len),
    .b(b), .c(c), .a(a), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outVec();
    return {b, c, a, busy, done, err};
  endfunction

  // Expected outputs for cycle F+k of a legal frame, straight from the timing rules.
  function automatic logic [5:0] expLegal(input int n, input int off, input int m, input int k);
    logic eb, ec, ea, ebusy, edone;
    eb    = (k < n);
    ec    = (k == n);
    ea    = (k >= off) && (k < off + m);
    ebusy = (k <= n);
    edone = (k == n + 1);
    return {eb, ec, ea, ebusy, edone, 1'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got b,c,a,busy,done,err=%b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    logic [5:0] e;
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(curTag, outVec(), e);
    end
  endtask

  task automatic applyStimulus(input logic s, input int n, input int off, input int m);
    start     = s;
    frame_len = LEN_W'(n);
    win_off   = LEN_W'(off);
    win_len   = LEN_W'(m);
  endtask

  task automatic runLegal(input string tag, input int n, input int off, input int m);
    curTag = tag;
    for (int k = 0; k <= n + 1; k++) expQ.push_back(expLegal(n, off, m, k));
    applyStimulus(1'b1, n, off, m);
    step();
    start = 1'b0;
    for (int k = 1; k <= n + 1; k++) step();
  endtask

  task automatic runIllegal(input string tag, input int n, input int off, input int m);
    curTag = tag;
    expQ.push_back(6'b000001);
    for (int k = 0; k < 9; k++) expQ.push_back(6'b0);
    applyStimulus(1'b1, n, off, m);
    step();
    start = 1'b0;
    for (int k = 1; k < 10; k++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 0);
    curTag = "reset";
    #3;
    checkOutput("reset_async", outVec(), 6'b0);
    for (int k = 0; k < 2; k++) begin expQ.push_back(6'b0); step(); end
    #2 rst_n = 1'b1;
    expQ.push_back(6'b0);
    step();

    runLegal("basic_n3_o0_m4", 3, 0, 4);
    runIllegal("illegal_window", 3, 1, 4);
    runIllegal("zero_n", 0, 0, 1);
    runIllegal("zero_m", 3, 0, 0);
    runIllegal("illegal_max", 15, 15, 2);
    runLegal("window_on_c", 4, 2, 3);
    runLegal("max_frame", 15, 14, 2);
    runLegal("single_cycle", 1, 1, 1);

    // A second start at F+2 must be ignored without err.
    curTag = "start_while_busy";
    for (int k = 0; k <= 7; k++) expQ.push_back(expLegal(5, 2, 2, k));
    applyStimulus(1'b1, 5, 2, 2);
    step();
    start = 1'b0;
    step();
    step();
    applyStimulus(1'b1, 1, 0, 1);
    step();
    start = 1'b0;
    for (int k = 4; k <= 7; k++) step();

    // Held start: frames at F, F+4, F+8 with a one-cycle done gap.
    curTag = "back_to_back";
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 4; k++) expQ.push_back(expLegal(2, 1, 2, k));
    expQ.push_back(6'b0);
    applyStimulus(1'b1, 2, 1, 2);
    for (int k = 0; k < 9; k++) step();
    start = 1'b0;
    for (int k = 9; k < 13; k++) step();

    // Reset at F+3 between edges; outputs must clear before the next edge.
    curTag = "reset_mid_frame";
    for (int k = 0; k < 3; k++) expQ.push_back(expLegal(7, 0, 8, k));
    applyStimulus(1'b1, 7, 0, 8);
    step();
    start = 1'b0;
    step();
    step();
    @(posedge clk);
    #1;
    checkOutput("pre_reset_f3", outVec(), expLegal(7, 0, 8, 3));
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_async_mid", outVec(), 6'b0);
    for (int k = 0; k < 2; k++) begin expQ.push_back(6'b0); step(); end
    #2 rst_n = 1'b1;
    curTag = "after_reset_no_done";
    for (int k = 0; k < 3; k++) begin expQ.push_back(6'b0); step(); end
    runLegal("after_reset_frame", 7, 0, 8);

    checkOutput("queue_drained", 6'(expQ.size()), 6'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/within_frame_gen.md
# within_frame_gen

Registered stimulus/driver block that produces the "window within frame" signal pattern consumed by the team's `within` sequence checkers. On a start request it drives a framing signal `b` for a programmed number of cycles, then a one-cycle terminator `c`. Inside that frame it drives a data-window signal `a` at a programmed offset and length. The block sits on the generator side of the b/c/a framing interface and feeds DUT inputs and assertion-checked testbenches.

## Interface
- `LEN_W`, 4: width of the length and offset fields. The frame length range is 1..2^LEN_W-1.
- `clk` input 1: clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: frame request; sampled only in IDLE.
- `frame_len` input LEN_W: N, the number of `b` cycles; 0 is illegal.
- `win_off` input LEN_W: offset of the first `a` cycle from the first `b` cycle.
- `win_len` input LEN_W: M, the number of `a` cycles; 0 is illegal.
- `b` output 1: frame body.
- `c` output 1: frame terminator pulse.
- `a` output 1: window signal.
- `busy` output 1: high from the first `b` cycle through the `c` cycle.
- `done` output 1: one-cycle pulse in the cycle after `c`.
- `err` output 1: one-cycle pulse when a start request is rejected.

## Operation
- **FSM states:** IDLE, BODY, TAIL. All outputs come straight from registers, with no combinational paths from inputs to outputs.
- **IDLE + start:**
  - Latch `frame_len`, `win_off` and `win_len`.
  - Compute `end = win_off + win_len` at LEN_W+1 bits so it cannot overflow.
  - The request is legal iff `frame_len != 0`, `win_len != 0` and `end <= frame_len + 1`. This keeps the `a` window inside the N+1-cycle span `b[*N] ##1 c`.
  - If legal: go to BODY and clear the position counter `pos` to 0.
  - If illegal: pulse `err`, stay in IDLE, and drive no `b`, `c` or `a`.
- **BODY:**
  - `b=1`, `busy=1`.
  - `pos` increments every cycle.
  - On the cycle where `pos == N-1`, go to TAIL next.
- **TAIL:**
  - `b=0`, `c=1`, `busy=1`, with `pos == N`.
  - Next state is IDLE, and `done` is pulsed in that first IDLE cycle.
- **Window:** `a=1` exactly when `busy` is high and `win_off <= pos < end`. The window may therefore cover the `c` cycle.
- **start outside IDLE:** ignored. It is not queued and does not raise `err`.
- **start and done in the same cycle:** `start` is accepted, because `done` is asserted while in IDLE.
- **Reset:** asynchronous assertion at any point, including mid-frame:
  - State returns to IDLE; `pos` and the latched fields go to 0.
  - Every output goes low immediately (`b`, `c`, `a`, `busy`, `done`, `err` all reset to 0).
  - No `done` is generated for an aborted frame.

## Timing
- Let the cycle in which `start` is sampled high in IDLE be S, and let F = S+1.
- **Legal request:**
  - `b` is high in F..F+N-1.
  - `c` is high in F+N.
  - `a` is high in F+win_off..F+win_off+M-1.
  - `busy` is high in F..F+N.
  - `done` is high in F+N+1.
- **Illegal request:** `err` is high in F only; every other output stays 0.
- **Latency:** one cycle from `start` to the first `b`. A frame occupies N+1 cycles.
- **Back-to-back frames:** minimum period is N+2 cycles, achieved with `start` held high or re-asserted during the `done` cycle. `b` is always low for at least one cycle between frames, so `$rose(b)` fires once per frame.
- **Config inputs** are sampled only at S. Changes during a frame have no effect on that frame.

## Test plan
- **Basic legal frame:** N=3, off=0, M=4, `start` at S.
  - Expected: `b` in F..F+2, `c` in F+3, `a` in F..F+3, `done` in F+4.
  - `$rose(b) |-> a[*4] within (b[*3] ##1 c)` passes.
- **Illegal window:** N=3, off=1, M=4 (end=5 > 4).
  - Expected: `err` in F only; `b`, `c`, `a` and `busy` stay 0 for 10 cycles.
- **Zero fields:** N=0, or M=0, with the other fields legal.
  - Expected: `err` pulses and no frame is produced.
- **Start while busy:** start N=5, off=2, M=2, then pulse `start` again at F+2 with N=1.
  - Expected: the first frame completes unchanged (`a` in F+2..F+3, `c` in F+5); no second frame and no `err`.
- **Back-to-back:** `start` held high with N=2, off=1, M=2.
  - Expected: frames start at F, F+4 and F+8; `b` is low at F+2, F+3, F+6, F+7; `done` in F+3 and F+7.
- **Reset mid-frame:** N=7, off=0, M=8; deassert `rst_n` at F+3 between clock edges, then release.
  - Expected: all outputs drop to 0 asynchronously; no `done`; a new `start` after release produces a normal frame.
